mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-port memory arbiter with WAIT timeout
// Define MEM_ARB_RR_EN for round-robin grants; default build is fixed data-over-fetch priority.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_done,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;  // 1: data port owns the transaction
  logic [7:0]          cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_ack_q, if_ack_d;
  logic                d_ack_q, d_ack_d;
  logic                err_q, err_d;
  logic                grant_data;

`ifdef MEM_ARB_RR_EN
  logic last_q;  // 1: data port won the previous grant

  assign grant_data = d_req && (!if_req || !last_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= 1'b0;
    end else if (state_q == IDLE && (if_req || d_req)) begin
      last_q <= grant_data;
    end
  end
`else
  assign grant_data = d_req;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d   = ISSUE;
          mem_req_d = 1'b1;
          cnt_d     = '0;
          owner_d   = grant_data;
          if (grant_data) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_be;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_be_d    = '1;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // A completion in the expiry cycle still counts as a normal response.
        if (mem_done) begin
          state_d  = RESP;
          d_ack_d  = owner_q;
          if_ack_d = !owner_q;
          if (owner_q) d_rdata_d = mem_rdata;
          else         if_rdata_d = mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = RESP;
          d_ack_d  = owner_q;
          if_ack_d = !owner_q;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign err       = err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a variable-latency memory model
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [3:0]    d_be = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_done = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic is_d; logic err; logic [31:0] rdata; } rsp_t;
  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } cmd_t;

  rsp_t exp_q[$];
  cmd_t cmd_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_mreq = 0;
  int n_ack = 0;
  int n_cmd = 0;
  int mem_delay = 1;
  int done_cyc = -1;
  int stray_cyc = -1;
  logic [31:0] mem_addr_l = '0;
  logic [31:0] exp_if_rd = '0;
  logic [31:0] exp_d_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h40) ? 32'h2008_0005 : {a[15:0], ~a[15:0]};
  endfunction

  // Memory model and response monitor; delay 0 means the memory never answers.
  initial begin
    cmd_t c;
    rsp_t r;
    forever begin
      @(negedge clk);
      mem_done  = (done_cyc == cyc) || (stray_cyc == cyc);
      mem_rdata = mem_done ? mem_fn(mem_addr_l) : (32'hBAD0_0000 ^ 32'(cyc));
      if (mem_req) begin
        n_mreq++;
        mem_addr_l = mem_addr;
        done_cyc   = (mem_delay == 0) ? -1 : cyc + mem_delay;
        if (cmd_q.size() == 0) begin
          check("cmd_unexpected", 64'd1, 64'd0);
        end else begin
          c = cmd_q.pop_front();
          check("mem_we", 64'(mem_we), 64'(c.we));
          check("mem_addr", 64'(mem_addr), 64'(c.addr));
          if (c.we) check("mem_wdata", 64'(mem_wdata), 64'(c.wdata));
          check("mem_be", 64'(mem_be), 64'(c.be));
        end
      end
      if (if_ack || d_ack) begin
        n_ack++;
        if (exp_q.size() == 0) begin
          check("ack_unexpected", 64'd1, 64'd0);
        end else begin
          r = exp_q.pop_front();
          check("ack_onehot", 64'(if_ack & d_ack), 64'd0);
          check("ack_owner", 64'(d_ack), 64'(r.is_d));
          check("err", 64'(err), 64'(r.err));
          check(r.is_d ? "d_rdata" : "if_rdata", 64'(r.is_d ? d_rdata : if_rdata), 64'(r.rdata));
        end
      end
    end
  end

  task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input int delay);
    bit   terr;
    bit   seen;
    int   r_cyc;
    int   lat;
    rsp_t r;
    cmd_t c;
    terr = (delay == 0) || (delay > TO);
    c.we = is_d ? we : 1'b0;
    c.addr = addr;
    c.wdata = wdata;
    c.be = is_d ? be : 4'hF;
    cmd_q.push_back(c);
    n_cmd++;
    r.is_d = is_d;
    r.err = terr;
    if (terr) begin
      r.rdata = is_d ? exp_d_rd : exp_if_rd;
    end else begin
      r.rdata = mem_fn(addr);
      if (is_d) exp_d_rd = r.rdata;
      else exp_if_rd = r.rdata;
    end
    exp_q.push_back(r);
    mem_delay = delay;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    r_cyc = cyc;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < TO + 10 && !seen; i++) begin
      @(negedge clk);
      if (if_ack || d_ack) begin
        seen = 1'b1;
        lat = cyc - r_cyc;
        d_req = 1'b0;
        if_req = 1'b0;
      end
    end
    check("ack_seen", 64'(seen), 64'd1);
    // IDLE, ISSUE, WAIT x n, RESP: ack lands (1 + n + 1) cycles after the request cycle.
    if (seen) check("latency", 64'(lat), 64'(terr ? TO + 2 : delay + 2));
    @(negedge clk);
    check("ack_pulse", 64'({if_ack, d_ack}), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    check({tag, "_acks"}, 64'({if_ack, d_ack}), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
    check({tag, "_d_rdata"}, 64'(d_rdata), 64'd0);
    check({tag, "_mem_cmd"}, 64'({mem_we, mem_be}), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  initial begin
    int   snap;
    int   grants;
    int   di;
    logic [31:0] d_addrs [2];
    logic [31:0] order_addr [3];
    logic        order_is_d [3];
    rsp_t r;
    cmd_t c;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 1);
    run_txn(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1);
    run_txn(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 0);
    run_txn(1'b1, 1'b0, 32'h0000_0204, 32'h0, 4'hF, TO);
    run_txn(1'b0, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 3);

    snap = n_ack;
    stray_cyc = cyc + 1;
    repeat (4) @(negedge clk);
    check("stray_noack", 64'(n_ack), 64'(snap));
    check("stray_if_rdata", 64'(if_rdata), 64'(exp_if_rd));
    check("stray_d_rdata", 64'(d_rdata), 64'(exp_d_rd));

    // Abandon a read in WAIT; its late completion must not resurrect an ack.
    c.we = 1'b0; c.addr = 32'h500; c.wdata = 32'h0; c.be = 4'hF;
    cmd_q.push_back(c);
    n_cmd++;
    mem_delay = 8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_be = 4'hF;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    check_reset_outputs("midop");
    rst = 1'b1;
    exp_if_rd = '0;
    exp_d_rd = '0;
    snap = n_ack;
    repeat (12) @(negedge clk);
    check("late_done_noack", 64'(n_ack), 64'(snap));
    check("late_done_d_rdata", 64'(d_rdata), 64'd0);

    d_addrs[0] = 32'h300;
    d_addrs[1] = 32'h304;
`ifdef MEM_ARB_RR_EN
    order_addr[0] = 32'h300; order_is_d[0] = 1'b1;
    order_addr[1] = 32'h080; order_is_d[1] = 1'b0;
    order_addr[2] = 32'h304; order_is_d[2] = 1'b1;
`else
    order_addr[0] = 32'h300; order_is_d[0] = 1'b1;
    order_addr[1] = 32'h304; order_is_d[1] = 1'b1;
    order_addr[2] = 32'h080; order_is_d[2] = 1'b0;
`endif
    for (int k = 0; k < 3; k++) begin
      c.we = 1'b0; c.addr = order_addr[k]; c.wdata = 32'h0; c.be = 4'hF;
      cmd_q.push_back(c);
      n_cmd++;
      r.is_d = order_is_d[k]; r.err = 1'b0; r.rdata = mem_fn(order_addr[k]);
      exp_q.push_back(r);
    end
    mem_delay = 1;
    d_req = 1'b1; d_we = 1'b0; d_addr = d_addrs[0]; d_be = 4'hF;
    if_req = 1'b1; if_addr = 32'h080;
    grants = 0;
    di = 0;
    for (int i = 0; i < 40 && grants < 3; i++) begin
      @(negedge clk);
      if (d_ack) begin
        grants++;
        di++;
        if (di == 2) d_req = 1'b0;
        else d_addr = d_addrs[di];
      end
      if (if_ack) begin
        grants++;
        if_req = 1'b0;
      end
    end
    check("contention_grants", 64'(grants), 64'd3);
    d_req = 1'b0;
    if_req = 1'b0;
    repeat (3) @(negedge clk);

    check("mem_req_count", 64'(n_mreq), 64'(n_cmd));
    check("rsp_queue_empty", 64'(exp_q.size()), 64'd0);
    check("cmd_queue_empty", 64'(cmd_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
